apa102_frame_latch: RTL
=======================

# apa102_frame_latch

Sits between the APA102 SPI receiver and the WS2812 driver. Accepts decoded 32-bit APA102 words and applies each pixel's 5-bit global brightness to its colour channels. Packs the result into the driver's GRB frame layout. A fresh frame is held in a back buffer and copied to the driver-facing front buffer only when a full frame has arrived and the driver is idle, so the driver never shows a half-updated frame.

## Interface
- LED_CNT, 7, pixels per frame
- CH_W, 3, output bits kept per colour channel (1..8)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle strobe: the upstream stage has seen the 32-zero APA102 start frame
- pix_valid  in  1  one-cycle strobe: pix_data holds a complete word
- pix_data  in  32  APA102 word: [31:29] header, [28:24] brightness, [23:16] B, [15:8] G, [7:0] R
- ws_busy  in  1  WS2812 driver is shifting out a frame
- load  out  1  one-cycle strobe: data_out has just taken a new frame
- data_out  out  LED_CNT*24  front buffer
  - pixel 0 in the MSBs
  - each pixel is G,R,B in that order
  - each channel is 8 bits: zeros, then the CH_W scaled bits in the LSBs
- err_cnt  out  8  saturating count of rejected words (bad header)
- ovr_cnt  out  8  saturating count of pending frames discarded before they could be loaded

## Operation
- States:
  - IDLE: waiting for a frame.
  - FILL: collecting pixel words into the back buffer.
  - PENDING: a complete frame is waiting for the driver.
- Write index idx, range 0..LED_CNT-1.
- frame_start, in any state: idx←0, state←FILL. It has priority over a simultaneous pix_valid, and that word is dropped without counting.
- frame_start while in PENDING: the pending frame is discarded, ovr_cnt+1.
- In FILL, pix_valid with pix_data[31:29]==3'b111:
  - write the scaled pixel to back[idx] and increment idx;
  - if this write was to idx==LED_CNT-1, state←PENDING.
- In FILL, pix_valid with any other header: word dropped, idx unchanged, err_cnt+1.
- pix_valid in IDLE or PENDING is ignored; nothing is counted. This covers the trailing APA102 end-frame words (0xFFFFFFFF).
- Scaling, per channel, with b = brightness:
  - s = (ch × (b+1)) >> 5, using a 13-bit product; s fits in 8 bits;
  - output = s[7:8-CH_W].
- In PENDING with ws_busy==0: front←back, load←1, state←IDLE.
- Counters saturate at 255 and never wrap.

## Timing
- Reset values:
  - state IDLE, idx 0, back and front buffers all zero;
  - data_out 0, load 0, err_cnt 0, ovr_cnt 0.
- Reset asserted mid-frame returns to these values on the next edge; partial data is lost.
- Pixel write: the word accepted at edge N is in back[] after edge N.
- Load: if the last pixel is accepted at edge N and ws_busy is low during cycle N..N+1, then:
  - at edge N+1, data_out updates and load rises;
  - load falls at edge N+2;
  - latency from last pixel to load is 1 cycle.
- If ws_busy is high, the block stays in PENDING. load rises at the first edge sampling ws_busy==0.
- load is never high for two consecutive cycles.
- data_out changes only at the edge where load rises.
- pix_valid is accepted on any cycle, including back-to-back; there is no backpressure upstream.

## Structure
- Shared package apa102_pkg holds:
  - the header constant 3'b111;
  - the state enum;
  - field positions (brightness, B, G, R) within the 32-bit word.
- One sub-module, apa102_scale: purely combinational, taking an 8-bit channel and 5-bit brightness and producing CH_W bits. It is instantiated three times (R, G, B).

## Test plan
- Full-brightness frame: frame_start, then 7 words 0xFF0080FF with ws_busy=0 → load pulses 1 cycle after the 7th word; every data_out pixel = 0x040700; err_cnt=0.
- Half brightness: 7 words 0xEF0080FF → each pixel = 0x020300.
- Driver busy: complete frame with ws_busy=1 for 20 cycles → no load and data_out unchanged until ws_busy falls; then load pulses exactly once.
- Bad header: frame_start, then 0x7F0080FF, then 7 valid words → err_cnt=1; the frame still loads with 7 valid pixels.
- Overrun and extra words:
  - frame_start while PENDING → ovr_cnt=1, data_out unchanged;
  - 9 words after frame_start → only the first 7 are stored, and the extra 2 are not counted.
- Reset mid-fill: reset after 3 words → all outputs 0; a subsequent full frame loads correctly.

Source files
------------

// File: rtl/apa102_pkg.sv
// apa102_pkg: shared APA102 word layout, header constant and frame-latch states
package apa102_pkg;

    localparam logic [2:0] HDR = 3'b111;

    localparam int HDR_HI = 31;
    localparam int HDR_LO = 29;
    localparam int BRI_HI = 28;
    localparam int BRI_LO = 24;
    localparam int B_HI   = 23;
    localparam int B_LO   = 16;
    localparam int G_HI   = 15;
    localparam int G_LO   = 8;
    localparam int R_HI   = 7;
    localparam int R_LO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PENDING
    } state_t;

endpackage

// File: rtl/apa102_frame_latch_if.sv
// apa102_frame_latch_if: pixel stream in, driver status in, latched frame and counters out
interface apa102_frame_latch_if #(
    parameter int LED_CNT = 7
);

    logic                   frame_start;
    logic                   pix_valid;
    logic [31:0]            pix_data;
    logic                   ws_busy;
    logic                   load;
    logic [LED_CNT*24-1:0]  data_out;
    logic [7:0]             err_cnt;
    logic [7:0]             ovr_cnt;

    modport master (
        output frame_start, pix_valid, pix_data, ws_busy,
        input  load, data_out, err_cnt, ovr_cnt
    );

    modport slave (
        input  frame_start, pix_valid, pix_data, ws_busy,
        output load, data_out, err_cnt, ovr_cnt
    );

endinterface

// File: rtl/apa102_scale.sv
// apa102_scale: apply 5-bit global brightness to one channel and keep the top CH_W bits
module apa102_scale #(
    parameter int CH_W = 3
) (
    input  logic [7:0]      ch,
    input  logic [4:0]      bri,
    output logic [CH_W-1:0] q
);

    logic [12:0] prod;

    // (ch * (b+1)) >> 5 fits in 8 bits, so its top CH_W bits are prod[12:13-CH_W]
    assign prod = 13'(ch) * 13'({1'b0, bri} + 6'd1);
    assign q    = CH_W'(prod >> (13 - CH_W));

endmodule

// File: rtl/apa102_frame_latch.sv
// apa102_frame_latch: brightness-scale APA102 pixels into a back buffer, hand full frames to the WS2812 driver
module apa102_frame_latch
    import apa102_pkg::*;
#(
    parameter int LED_CNT = 7,
    parameter int CH_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    apa102_frame_latch_if.slave bus
);

    localparam int IW = LED_CNT > 1 ? $clog2(LED_CNT) : 1;
    localparam int W  = LED_CNT * 24;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [23:0]     back [LED_CNT];
    logic [W-1:0]    back_flat;
    logic [W-1:0]    front;
    logic            load;
    logic [7:0]      err_cnt;
    logic [7:0]      ovr_cnt;
    logic [CH_W-1:0] r_s;
    logic [CH_W-1:0] g_s;
    logic [CH_W-1:0] b_s;
    logic [23:0]     pix;
    logic            hdr_ok;
    logic            last;

    apa102_scale #(.CH_W(CH_W)) u_scale_r (
        .ch  (bus.pix_data[R_HI:R_LO]),
        .bri (bus.pix_data[BRI_HI:BRI_LO]),
        .q   (r_s)
    );

    apa102_scale #(.CH_W(CH_W)) u_scale_g (
        .ch  (bus.pix_data[G_HI:G_LO]),
        .bri (bus.pix_data[BRI_HI:BRI_LO]),
        .q   (g_s)
    );

    apa102_scale #(.CH_W(CH_W)) u_scale_b (
        .ch  (bus.pix_data[B_HI:B_LO]),
        .bri (bus.pix_data[BRI_HI:BRI_LO]),
        .q   (b_s)
    );

    assign pix    = {8'(g_s), 8'(r_s), 8'(b_s)};
    assign hdr_ok = bus.pix_data[HDR_HI:HDR_LO] == HDR;
    assign last   = idx == IW'(LED_CNT - 1);

    // flatten the back buffer with pixel 0 in the most significant slot
    always_comb begin
        back_flat = '0;
        for (int i = 0; i < LED_CNT; i++) back_flat[(LED_CNT-1-i)*24 +: 24] = back[i];
    end

    // frame FSM: fill the back buffer, then copy it to the front once the driver is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            load    <= 1'b0;
            front   <= '0;
            err_cnt <= '0;
            ovr_cnt <= '0;
            for (int i = 0; i < LED_CNT; i++) back[i] <= '0;
        end else begin
            load <= 1'b0;
            if (bus.frame_start) begin
                idx   <= '0;
                state <= FILL;
                if (state == PENDING) ovr_cnt <= ovr_cnt + {7'd0, ovr_cnt != 8'hFF};
            end else begin
                case (state)
                    FILL: begin
                        if (bus.pix_valid && hdr_ok) begin
                            back[idx] <= pix;
                            idx       <= last ? '0 : idx + 1'b1;
                            if (last) state <= PENDING;
                        end else if (bus.pix_valid) begin
                            err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
                        end
                    end
                    PENDING: begin
                        if (!bus.ws_busy) begin
                            front <= back_flat;
                            load  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.load     = load;
    assign bus.data_out = front;
    assign bus.err_cnt  = err_cnt;
    assign bus.ovr_cnt  = ovr_cnt;

endmodule
